dram_rr_arbiter: RTL
====================

Name: dram_rr_arbiter

Overview:
Round-robin arbiter that shares one single-port synchronous data RAM between N_REQ cores.
- Each core issues level read or write requests and waits for a one-cycle acknowledge pulse on its `acq` bit.
- Sits between the core array and DRAM, driving the RAM address, data and write-enable from the granted core.
- Read data returns on a per-core data slice.

Parameters:
N_REQ, 8, number of requesters (cores)
AW, 8, RAM address width
DW, 8, RAM data width
RD_LAT, 1, RAM read latency in cycles from the address-sampling edge to q valid (1..3)

Ports:
CLK  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rden  input  N_REQ  per-core read request, level
wren  input  N_REQ  per-core write request, level; wins over rden of the same core
Address  input  N_REQ*AW  per-core address, slice i = core i
Din  input  N_REQ*DW  per-core write data
RAMq  input  DW  RAM read data
acq  output  N_REQ  one-cycle acknowledge per core
Dq  output  N_REQ*DW  per-core read data, held until that core's next read completes
RAMAddress  output  AW  registered RAM address
RAMDin  output  DW  registered RAM write data
RAMwren  output  1  registered RAM write enable
busy  output  1  high when state != IDLE or any request is pending

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and ptr to 0.
  - acq, Dq, RAMAddress, RAMDin and RAMwren all go to 0 immediately.
  - Reset mid-transaction abandons the transaction; no acq is issued.
- Request contract: a core holds rden/wren, Address and Din stable until it sees its acq bit high, then drops the request on the next edge. Requests never acknowledged stay pending indefinitely.
- Round-robin: in IDLE, the requester set is req = rden | wren. The grant g is the first set bit searching from ptr upward, modulo N_REQ. After the grant, ptr = (g+1) mod N_REQ. Reset ptr = 0.
- States:
  - IDLE:
    - req == 0: stay; RAMwren = 0.
    - Otherwise, at edge E0: latch g; drive RAMAddress = Address[g], RAMDin = Din[g], RAMwren = wren[g].
    - Go to WR if wren[g], else to RD.
  - WR:
    - acq[g] = 1 for exactly this cycle; RAM samples the write at E1.
    - At E1: RAMwren goes to 0 and state goes to IDLE.
  - RD:
    - RAMwren = 0; counter counts RD_LAT cycles after E1.
    - At edge E(1+RD_LAT): Dq[g] = RAMq; go to DONE.
  - DONE: acq[g] = 1 for one cycle; go to IDLE at the next edge.
- Latency:
  - Write acq is high in the cycle after E0.
  - Read acq is high in the cycle after E(1+RD_LAT), i.e. 3 cycles after sampling when RD_LAT=1.
  - IDLE always follows a completed transaction, so a dropped request is never re-granted.
  - Throughput: one write per 2 cycles; one read per (3+RD_LAT) cycles.
- Simultaneous events:
  - rden and wren both set for one core: treated as a write; rden is ignored for that grant.
  - Requests arriving outside IDLE wait; only IDLE samples requests.
- acq is one-hot or zero at all times.
- Dq slices of non-granted cores never change.
- Wrap: ptr wraps N_REQ-1 → 0. With all bits requesting continuously, grants cycle 0,1,…,N_REQ-1,0.
- RAMAddress and RAMDin hold their last value in IDLE; only RAMwren is forced to 0.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs grant_cnt[31:0] (increments on every acq pulse) and wait_cnt[31:0] (increments every cycle in which req has a set bit whose core is not the current grantee).
  - Both counters saturate at 0xFFFFFFFF.
  - Both reset to 0 on rst_n.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Single write: core 2 wren=1, Address=0x10, Din=0xA5 → RAMwren=1 with RAMAddress=0x10 and RAMDin=0xA5 one cycle after sampling; acq=0x04 for 1 cycle; readback by core 2 gives Dq[2]=0xA5.
- Single read, RD_LAT=1: RAM preloaded with 0x3C at 0x20; core 5 rden at 0x20 → acq=0x20 high 3 cycles after sampling; Dq[5]=0x3C; other Dq slices unchanged.
- Round-robin fairness: all 8 cores request continuous reads from reset → acq order 0,1,…,7,0; each core waits at most 7 transactions.
- Priority rotation: ptr=3 after granting core 2; cores 1 and 6 request together → core 6 granted first, then core 1.
- Reset mid-read: assert rst_n=0 in RD → acq, RAMwren and Dq go to 0 immediately; after release, the still-held request is re-granted from ptr=0.
- ARB_STATS_EN: cores 0 and 1 issue 4 writes each, requests held continuously → grant_cnt=8 and wait_cnt>0; the build without the macro compiles without these ports.

Source files
------------

// File: rtl/dram_rr_arbiter_if.sv
// Core-array / RAM bundle for dram_rr_arbiter.
// slave is the arbiter's view of the bundle; master is the view of the cores and the RAM.
interface dram_rr_arbiter_if #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
);
  // Core side: level requests, per-core address/data slices, acknowledge and read data
  logic [N_REQ-1:0]    rden;
  logic [N_REQ-1:0]    wren;
  logic [N_REQ*AW-1:0] Address;
  logic [N_REQ*DW-1:0] Din;
  logic [N_REQ-1:0]    acq;
  logic [N_REQ*DW-1:0] Dq;
  // RAM side
  logic [DW-1:0]       RAMq;
  logic [AW-1:0]       RAMAddress;
  logic [DW-1:0]       RAMDin;
  logic                RAMwren;
  // Status
  logic                busy;

  modport slave (
    input  rden, wren, Address, Din, RAMq,
    output acq, Dq, RAMAddress, RAMDin, RAMwren, busy
  );

  modport master (
    output rden, wren, Address, Din, RAMq,
    input  acq, Dq, RAMAddress, RAMDin, RAMwren, busy
  );
endinterface

// File: rtl/dram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between N_REQ cores.
// IDLE picks the first requester from ptr upward; writes finish in WR, reads wait
// RD_LAT cycles in RD for RAMq and acknowledge in DONE.
// Optional macro ARB_STATS_EN adds saturating grant_cnt / wait_cnt outputs.
module dram_rr_arbiter #(
  parameter int unsigned N_REQ  = 8,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  dram_rr_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt,
  output logic [31:0]       wait_cnt
`endif
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gnt_q, gnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]    acq_q, acq_d;
  logic [N_REQ*DW-1:0] dq_q, dq_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       din_q, din_d;
  logic                wren_q, wren_d;

  logic [N_REQ-1:0]    req;
  logic [PW-1:0]       pick;
  logic                pick_vld;

  assign req = bus.rden | bus.wren;

  // Rotating priority search: first requester at or above ptr, wrapping modulo N_REQ
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_vld && req[(32'(ptr_q) + k) % N_REQ]) begin
        pick     = PW'((32'(ptr_q) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic; RAMwren and acq default low every cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    acq_d   = '0;
    dq_d    = dq_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wren_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d  = pick;
          ptr_d  = (32'(pick) == N_REQ - 1) ? '0 : PW'(32'(pick) + 1);
          addr_d = bus.Address[32'(pick)*AW +: AW];
          din_d  = bus.Din[32'(pick)*DW +: DW];
          cnt_d  = '0;
          // wren wins over rden of the same core
          if (bus.wren[pick]) begin
            wren_d      = 1'b1;
            acq_d[pick] = 1'b1;
            state_d     = S_WR;
          end else begin
            state_d     = S_RD;
          end
        end
      end
      S_WR: begin
        state_d = S_IDLE;
      end
      S_RD: begin
        if (32'(cnt_q) == RD_LAT) begin
          dq_d[32'(gnt_q)*DW +: DW] = bus.RAMq;
          acq_d[gnt_q]              = 1'b1;
          state_d                   = S_DONE;
        end else begin
          cnt_d = CW'(32'(cnt_q) + 1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      acq_q   <= '0;
      dq_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      acq_q   <= acq_d;
      dq_q    <= dq_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wren_q  <= wren_d;
    end
  end

  assign bus.acq        = acq_q;
  assign bus.Dq         = dq_q;
  assign bus.RAMAddress = addr_q;
  assign bus.RAMDin     = din_q;
  assign bus.RAMwren    = wren_q;
  assign bus.busy       = (state_q != S_IDLE) || (|req);

`ifdef ARB_STATS_EN
  logic [31:0]      grant_cnt_q;
  logic [31:0]      wait_cnt_q;
  logic [N_REQ-1:0] owner;

  // The current grantee exists only outside IDLE
  always_comb begin
    owner = '0;
    if (state_q != S_IDLE) owner[gnt_q] = 1'b1;
  end

  // Saturating activity counters
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if ((|acq_q) && (grant_cnt_q != 32'hFFFF_FFFF)) grant_cnt_q <= grant_cnt_q + 32'd1;
      if ((|(req & ~owner)) && (wait_cnt_q != 32'hFFFF_FFFF)) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule
